// File: rtl/ifid_pkg.sv
// ifid_pkg: shared types and constants for the IF/ID decoupling queue.
//
// Contents:
//   DEFAULT_DEPTH  default number of queue entries (power of two, >= 2)
//   NOP_INST       instruction shown to decode on a bubble when the
//                  IFID_BUBBLE_NOP_EN macro is defined
//   ifid_entry_t   one queued {inst, pc} pair
//
// `COMMON_WIDTH normally comes from common_def.h; the fallback below keeps
// this slice self-contained when that header is not on the include path.

`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif

package ifid_pkg;

    localparam int DEFAULT_DEPTH = 2;

    localparam logic [`COMMON_WIDTH-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [`COMMON_WIDTH-1:0] inst;
        logic [`COMMON_WIDTH-1:0] pc;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_fifo_ctrl.sv
// ifid_fifo_ctrl: pointer, occupancy and handshake control for ifid_queue.
//
// Ports:
//   clk, rst      pipeline clock, synchronous active-high reset
//   flush         jump redirect; clears pointers and count, beats push/pop
//   fetch_valid   fetch presents a pair this cycle
//   id_ready      decode consumes the head this cycle
//   fetch_ready   queue not full (registered state only)
//   id_valid      queue not empty (registered state only)
//   wr_en         write the fetch pair into entry[wr_ptr] at this edge
//   wr_ptr        next slot to write
//   rd_ptr        head slot
//   count         occupancy, 0..DEPTH
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high; ready never depends combinationally on the partner's valid or ready.

module ifid_fifo_ctrl
    import ifid_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fetch_valid,
    input  logic             id_ready,
    output logic             fetch_ready,
    output logic             id_valid,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign fetch_ready = !full;
    assign id_valid    = !empty;

    // When full, no push even if a pop frees a slot this same cycle.
    assign push  = fetch_valid && !full;
    assign pop   = !empty && id_ready;
    // A flushed cycle's fetch pair is wrong-path: do not store it.
    assign wr_en = push && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifid_queue.sv
// ifid_queue: FIFO decoupling buffer between fetch and decode, replacing
// the bare IF/ID register. First-word fall-through: the head entry is
// driven combinationally onto id_inst/id_pc. A pushed pair appears on the
// id_* outputs the cycle after it is captured; there is no bypass.
//
// Ports:
//   clk, rst      pipeline clock, synchronous active-high reset
//   flush         jump redirect; discards all entries and the current pair
//   fetch_valid   fetch presents {fetch_inst, fetch_pc}
//   fetch_inst    fetched instruction
//   fetch_pc      address of fetch_inst
//   fetch_ready   queue accepts a pair this cycle (feeds fetch stall)
//   id_valid      head entry valid
//   id_inst       head instruction
//   id_pc         head pc
//   id_ready      decode consumes the head
//
// Configuration macro IFID_BUBBLE_NOP_EN: when defined, id_inst/id_pc show
// NOP/0 whenever id_valid is low; otherwise they show the (stale) entry at
// the read pointer and decode must qualify with id_valid.

module ifid_queue
    import ifid_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [`COMMON_WIDTH-1:0] fetch_inst,
    input  logic [`COMMON_WIDTH-1:0] fetch_pc,
    output logic                     fetch_ready,
    output logic                     id_valid,
    output logic [`COMMON_WIDTH-1:0] id_inst,
    output logic [`COMMON_WIDTH-1:0] id_pc,
    input  logic                     id_ready
);

    ifid_entry_t      mem [DEPTH];
    ifid_entry_t      head;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    ifid_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .id_ready    (id_ready),
        .fetch_ready (fetch_ready),
        .id_valid    (id_valid),
        .wr_en       (wr_en),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count)
    );

    // Storage is cleared on reset so id_inst/id_pc read 0 afterwards;
    // flush only resets the pointers and leaves the contents stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= '{inst: fetch_inst, pc: fetch_pc};
        end
    end

    assign head = mem[rd_ptr];

`ifdef IFID_BUBBLE_NOP_EN
    assign id_inst = id_valid ? head.inst : NOP_INST;
    assign id_pc   = id_valid ? head.pc   : '0;
`else
    assign id_inst = head.inst;
    assign id_pc   = head.pc;
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: self-checking bench for ifid_queue (DEPTH = 2).
// Each scenario task drives fetch/decode and checks the outputs against a
// scoreboard queue of expected {inst, pc} pairs.

`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif

module tb_ifid_queue;

    localparam int DEPTH = 2;
    localparam int W     = `COMMON_WIDTH;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst;
    logic         flush;
    logic         fetch_valid;
    logic [W-1:0] fetch_inst;
    logic [W-1:0] fetch_pc;
    logic         fetch_ready;
    logic         id_valid;
    logic [W-1:0] id_inst;
    logic [W-1:0] id_pc;
    logic         id_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ifid_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    int tests_run;
    int tests_failed;

    // ---------------- driver ----------------
    // Drive one cycle of stimulus, check handshake outputs and any popped
    // head against the scoreboard, then advance past the clock edge.
    task automatic cycle(input logic fv, input logic [W-1:0] inst,
                         input logic [W-1:0] pc, input logic rdy,
                         input logic fl, output logic accepted);
        logic [2*W-1:0] head;
        logic           exp_ready;
        logic           exp_valid;
        fetch_valid = fv;
        fetch_inst  = inst;
        fetch_pc    = pc;
        id_ready    = rdy;
        flush       = fl;
        #1;
        exp_ready = (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() != 0);
        tests_run++;
        if (fetch_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL fetch_ready: got %b expected %b", fetch_ready, exp_ready);
        end
        tests_run++;
        if (id_valid !== exp_valid) begin
            tests_failed++;
            $display("FAIL id_valid: got %b expected %b", id_valid, exp_valid);
        end
        accepted = fv && exp_ready && !fl;
        if (!fl && rdy && exp_valid) begin
            head = exp_q.pop_front();
            tests_run++;
            if ({id_inst, id_pc} !== head) begin
                tests_failed++;
                $display("FAIL pop_data: got inst=%h pc=%h expected inst=%h pc=%h",
                         id_inst, id_pc, head[2*W-1:W], head[W-1:0]);
            end
        end
        if (fl) exp_q.delete();
        else if (accepted) exp_q.push_back({inst, pc});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] inst_of(input logic [W-1:0] pc);
        return 32'hA500_0000 ^ (pc << 4);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic acc;
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; id_ready = 1'b0;
        fetch_inst = '0; fetch_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
            tests_run++;
            if (dut.u_ctrl.count !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_count: got %0d expected 0", dut.u_ctrl.count);
            end
            tests_run++;
            if (id_inst !== '0 || id_pc !== '0) begin
                tests_failed++;
                $display("FAIL reset_data: got inst=%h pc=%h expected 0/0", id_inst, id_pc);
            end
        end
    endtask

    task automatic test_fill_full();
        logic acc;
        cycle(1'b1, inst_of(32'h00), 32'h00, 1'b0, 1'b0, acc);
        cycle(1'b1, inst_of(32'h04), 32'h04, 1'b0, 1'b0, acc);
        // Third pair must be refused: fetch_ready is checked low here.
        cycle(1'b1, inst_of(32'h08), 32'h08, 1'b0, 1'b0, acc);
        tests_run++;
        if (dut.u_ctrl.count !== 2'd2) begin
            tests_failed++;
            $display("FAIL full_count: got %0d expected 2", dut.u_ctrl.count);
        end
        tests_run++;
        if (id_pc !== 32'h00 || id_inst !== inst_of(32'h00)) begin
            tests_failed++;
            $display("FAIL full_head: got pc=%h expected pc=00000000", id_pc);
        end
    endtask

    task automatic test_full_pop();
        logic acc;
        // Pop 0x00 while full: 0x08 still refused this cycle.
        cycle(1'b1, inst_of(32'h08), 32'h08, 1'b1, 1'b0, acc);
        tests_run++;
        if (dut.u_ctrl.count !== 2'd1) begin
            tests_failed++;
            $display("FAIL full_pop_count: got %0d expected 1", dut.u_ctrl.count);
        end
        // Slot now free: 0x08 accepted while 0x04 pops.
        cycle(1'b1, inst_of(32'h08), 32'h08, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
        tests_run++;
        if (id_valid !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL full_pop_drain: got id_valid=%b expected 0", id_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic         acc;
        logic [W-1:0] pc;
        for (int i = 0; i < 8; i++) begin
            pc = 32'h100 + 32'(i * 4);
            cycle(1'b1, inst_of(pc), pc, 1'b1, 1'b0, acc);
            // Steady state: one in, one out each cycle, occupancy stays 1.
            tests_run++;
            if (dut.u_ctrl.count !== 2'd1) begin
                tests_failed++;
                $display("FAIL stream_count: got %0d expected 1 at pc=%h", dut.u_ctrl.count, pc);
            end
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_random_stream();
        logic         acc;
        logic [W-1:0] pc;
        pc = 32'h1000;
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), inst_of(pc), pc,
                  1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) pc = pc + 32'h4;
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
        end
    endtask

    task automatic test_flush();
        logic acc;
        cycle(1'b1, inst_of(32'h30), 32'h30, 1'b0, 1'b0, acc);
        cycle(1'b1, inst_of(32'h34), 32'h34, 1'b0, 1'b0, acc);
        cycle(1'b1, inst_of(32'h38), 32'h38, 1'b1, 1'b1, acc);
        tests_run++;
        if (id_valid !== 1'b0 || fetch_ready !== 1'b1 || dut.u_ctrl.count !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_state: got id_valid=%b fetch_ready=%b count=%0d expected 0/1/0",
                     id_valid, fetch_ready, dut.u_ctrl.count);
        end
        cycle(1'b1, inst_of(32'h200), 32'h200, 1'b0, 1'b0, acc);
        tests_run++;
        if (id_pc !== 32'h200) begin
            tests_failed++;
            $display("FAIL flush_target: got pc=%h expected 00000200", id_pc);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_reset_mid();
        logic acc;
        cycle(1'b1, inst_of(32'h60), 32'h60, 1'b0, 1'b0, acc);
        cycle(1'b1, inst_of(32'h64), 32'h64, 1'b0, 1'b0, acc);
        rst = 1'b1; fetch_valid = 1'b1; id_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; fetch_valid = 1'b0; id_ready = 1'b0;
        exp_q.delete();
        tests_run++;
        if (id_valid !== 1'b0 || fetch_ready !== 1'b1 || dut.u_ctrl.count !== 2'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got id_valid=%b fetch_ready=%b count=%0d expected 0/1/0",
                     id_valid, fetch_ready, dut.u_ctrl.count);
        end
        tests_run++;
        if (id_inst !== '0 || id_pc !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_data: got inst=%h pc=%h expected 0/0", id_inst, id_pc);
        end
    endtask

    task automatic test_bubble();
        logic         acc;
        logic [W-1:0] exp_inst;
        logic [W-1:0] exp_pc;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        // Fill both slots with the marker so the slot under rd_ptr holds it.
        cycle(1'b1, 32'h2402_0005, 32'h500, 1'b0, 1'b0, acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h2402_0005, 32'h504, 1'b0, 1'b0, acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
`ifdef IFID_BUBBLE_NOP_EN
        exp_inst = 32'h0;
        exp_pc   = 32'h0;
`else
        exp_inst = 32'h2402_0005;
        exp_pc   = 32'h500;
`endif
        tests_run++;
        if (id_inst !== exp_inst || id_pc !== exp_pc) begin
            tests_failed++;
            $display("FAIL bubble_out: got inst=%h pc=%h expected inst=%h pc=%h",
                     id_inst, id_pc, exp_inst, exp_pc);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fill_full();
        test_full_pop();
        test_back_to_back();
        test_random_stream();
        test_flush();
        test_reset_mid();
        test_bubble();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Decoupling buffer between the fetch stage (pif) and decode, replacing a bare IF/ID register.
- Captures {inst, pc_addr} pairs from fetch and presents them to decode in FIFO order.
- Decode runs on a valid/ready handshake; fetch is back-pressured when the queue is full.
- A jump redirect or reset flushes all entries so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- flush  input  1  jump redirect (jump_en from the jump/stall unit); discards all entries
- fetch_valid  input  1  fetch presents a valid pair this cycle
- fetch_inst  input  `COMMON_WIDTH (32)  fetched instruction
- fetch_pc  input  `COMMON_WIDTH (32)  address of fetch_inst
- fetch_ready  output  1  queue accepts a pair this cycle; feeds the fetch stall term
- id_valid  output  1  head entry valid
- id_inst  output  `COMMON_WIDTH  head instruction
- id_pc  output  `COMMON_WIDTH  head pc
- id_ready  input  1  decode consumes head (deasserted on full_stall)

Behaviour:
- Storage: DEPTH-entry array of {inst, pc}, plus wr_ptr and rd_ptr (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits, range 0..DEPTH).
- push = fetch_valid && fetch_ready; pop = id_valid && id_ready.
- fetch_ready = (count != DEPTH). It depends only on registered state, with no combinational path from id_ready.
- id_valid = (count != 0). id_inst and id_pc come combinationally from entry[rd_ptr] (first-word fall-through).
- Latency: a pair pushed at edge N is visible on id_* in the cycle after edge N. There is no pass-through when the queue is empty.
- On push: entry[wr_ptr] <= fetch pair; wr_ptr++.
- On pop: rd_ptr++.
- count update: push only +1; pop only -1; push and pop together unchanged.
- Full (count==DEPTH): fetch_ready=0, so no push occurs even if a pop happens the same cycle. The slot frees one cycle later.
- Empty (count==0): id_valid=0; id_ready is ignored.
- Flush is priority over push and pop in the same cycle. It sets wr_ptr=rd_ptr=count=0, and the fetch pair presented that cycle is dropped. In the next cycle id_valid=0 and fetch_ready=1.
- Reset behaves as flush: count=0, pointers=0, id_valid=0, fetch_ready=1. id_inst and id_pc are 0 after reset because the storage array is cleared on rst.
- rst asserted mid-stream discards all entries regardless of the handshakes.
- Ordering is strict FIFO. No entry is duplicated or lost except by flush or reset.

Optional Feature:
- Macro: IFID_BUBBLE_NOP_EN.
- Defined: when id_valid=0, id_inst=32'h0000_0000 (NOP) and id_pc=32'h0. Decode may then ignore id_valid.
- Undefined: id_inst and id_pc always show entry[rd_ptr], which is stale data when empty. Decode must qualify with id_valid.
- Handshake and count behaviour are identical in both builds.

Decomposition:
- Shared package (ifid_pkg):
  - typedef ifid_entry_t = struct packed {inst, pc}, each `COMMON_WIDTH;
  - localparam NOP_INST = 32'h0;
  - default DEPTH.
- `COMMON_WIDTH stays in common_def.h.
- One natural sub-module, ifid_fifo_ctrl: pointers, count, push/pop/flush arbitration, full/empty flags. The top level holds the storage array and output muxing.

Test Plan:
- Reset, then idle: fetch_valid=0 for 3 cycles -> id_valid=0, fetch_ready=1, count=0, id_inst=0.
- Push pc 0x00/0x04/0x08 with id_ready=0 and DEPTH=2 -> fetch_ready drops after the second push, 0x08 is refused and held by fetch, and the head is pc 0x00.
- From full, id_ready=1 and fetch_valid=1 in the same cycle -> 0x00 pops, no push that cycle, then 0x08 is accepted next cycle. Decode order is 0x00, 0x04, 0x08.
- Streaming with fetch_valid=1 and id_ready=1 throughout, pc 0x100..0x11C -> one instruction per cycle at decode after a 1-cycle fill. There are no gaps and pointers wrap correctly.
- With 2 entries held, flush=1 together with fetch_valid=1 and id_ready=1 -> next cycle count=0 and id_valid=0. The flushed-cycle pair never appears, and the next push (jump target 0x200) is the first one decoded.
- With IFID_BUBBLE_NOP_EN defined, the queue empty and the last entry 0x2402_0005 -> id_inst=0 and id_pc=0. With the macro undefined, the same stimulus gives id_inst=0x2402_0005.
